// File: rtl/udp_payload_scheduler_pkg.sv
// Shared types and helpers for the UDP payload scheduler: FSM state encoding,
// bytes-per-word calculation and the header byte layout.
package udp_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    SEQ   = 3'd2,
    LOAD  = 3'd3,
    SHIFT = 3'd4,
    GAP   = 3'd5
  } state_t;

  // Header byte layout: source ID in the low nibble, upper bits zero.
  localparam int HDR_ID_LSB = 0;
  localparam int HDR_ID_W   = 4;

  // Number of output bytes carried by one packed word.
  function automatic int calc_nb(input int bw, input int n_prl, input int bw_out);
    return (bw * n_prl) / bw_out;
  endfunction

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/udp_payload_scheduler_if.sv
// Source-side and byte-stream-side signals of the UDP payload scheduler.
// master: the scheduler; slave: the surrounding producers and packetizer.
interface udp_sched_if #(
  parameter int DATA_W = 72,
  parameter int BYTE_W = 8,
  parameter int N_SRC  = 4
) ();

  logic [N_SRC-1:0]             src_valid;
  logic [N_SRC-1:0][DATA_W-1:0] src_data;
  logic [N_SRC-1:0]             src_ready;
  logic [BYTE_W-1:0]            m_data;
  logic                         m_valid;
  logic                         m_ready;
  logic                         m_first;
  logic                         m_last;

  modport master (
    input  src_valid, src_data, m_ready,
    output src_ready, m_data, m_valid, m_first, m_last
  );

  modport slave (
    output src_valid, src_data, m_ready,
    input  src_ready, m_data, m_valid, m_first, m_last
  );

endinterface

// File: rtl/udp_payload_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr,
// wrapping around, and reports it both one-hot and as an index.
module rr_arbiter
  import udp_sched_pkg::*;
#(
  parameter  int N_SRC = 4,
  localparam int GW    = cnt_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic [N_SRC-1:0] grant,
  output logic [GW-1:0]    idx,
  output logic             hit
);

  logic [GW-1:0] cand;

  // Scan from ptr upward with wrap; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = GW'((int'(ptr) + i) % N_SRC);
      if (!hit && req[cand]) begin
        hit         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_payload_scheduler.sv
// UDP payload scheduler: round-robin shares one byte stream among N_SRC
// packed-word producers. Each packet is locked to one source and carries a
// source-ID header byte followed by WORDS_PER_PKT words sent LSB byte first,
// then an inter-packet gap of IFG_CYCLES idle cycles.
// Optional build macro UDP_SCHED_SEQ_EN inserts a two-byte little-endian
// packet sequence number (pkt_count at header time) after the header.
module udp_payload_scheduler
  import udp_sched_pkg::*;
#(
  parameter  int BW            = 18,
  parameter  int N_PRL         = 4,
  parameter  int BW_out        = 8,
  parameter  int N_SRC         = 4,
  parameter  int WORDS_PER_PKT = 16,
  parameter  int IFG_CYCLES    = 4,
  localparam int GW            = cnt_w(N_SRC)
) (
  input  logic          clk,
  input  logic          rst,
  udp_sched_if.master   bus,
  output logic [GW-1:0] grant_id,
  output logic          busy,
  output logic [15:0]   pkt_count
);

  localparam int DATA_W = BW * N_PRL;
  localparam int NB     = calc_nb(BW, N_PRL, BW_out);
  localparam int BCW    = cnt_w(NB);
  localparam int WCW    = cnt_w(WORDS_PER_PKT);

  localparam logic [BCW-1:0] BYTE_LAST = BCW'(NB - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(WORDS_PER_PKT - 1);
  localparam logic [7:0]     GAP_LAST  = 8'(IFG_CYCLES - 1);

  state_t              state;
  state_t              state_nx;
  logic [GW-1:0]       ptr;
  logic [N_SRC-1:0]    grant_vec;
  logic [WCW-1:0]      word_cnt;
  logic [BCW-1:0]      byte_cnt;
  logic [7:0]          gap_cnt;
  logic [DATA_W-1:0]   shreg;
`ifdef UDP_SCHED_SEQ_EN
  logic                seq_idx;
`endif

  logic [N_SRC-1:0]    arb_grant;
  logic [GW-1:0]       arb_idx;
  logic                arb_hit;
  logic                last_byte;
  logic                last_word;
  logic                word_avail;

  // Source ID zero-extended into its field of the header byte.
  function automatic logic [BW_out-1:0] hdr_fmt(input logic [GW-1:0] id);
    logic [BW_out-1:0] b;
    b = '0;
    b[HDR_ID_LSB +: HDR_ID_W] = HDR_ID_W'(id);
    return b;
  endfunction

  rr_arbiter #(.N_SRC(N_SRC)) u_arb (
    .req   (bus.src_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .hit   (arb_hit)
  );

  assign last_byte  = (byte_cnt == BYTE_LAST);
  assign last_word  = (word_cnt == WORD_LAST);
  assign word_avail = |(grant_vec & bus.src_valid);
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and stream/handshake outputs.
  always_comb begin
    state_nx      = state;
    bus.m_valid   = 1'b0;
    bus.m_first   = 1'b0;
    bus.m_last    = 1'b0;
    bus.m_data    = '0;
    bus.src_ready = '0;
    case (state)
      IDLE: begin
        if (arb_hit) state_nx = HDR;
      end
      HDR: begin
        bus.m_valid = 1'b1;
        bus.m_first = 1'b1;
        bus.m_data  = hdr_fmt(grant_id);
`ifdef UDP_SCHED_SEQ_EN
        if (bus.m_ready) state_nx = SEQ;
`else
        if (bus.m_ready) state_nx = LOAD;
`endif
      end
`ifdef UDP_SCHED_SEQ_EN
      SEQ: begin
        bus.m_valid = 1'b1;
        bus.m_data  = BW_out'(seq_idx ? pkt_count[15:8] : pkt_count[7:0]);
        if (bus.m_ready && seq_idx) state_nx = LOAD;
      end
`endif
      LOAD: begin
        // Only the locked source is ever acknowledged, so ready stays one-hot.
        bus.src_ready = grant_vec & bus.src_valid;
        if (word_avail) state_nx = SHIFT;
      end
      SHIFT: begin
        bus.m_valid = 1'b1;
        bus.m_data  = shreg[BW_out-1:0];
        bus.m_last  = last_byte && last_word;
        if (bus.m_ready && last_byte) begin
          if (!last_word)           state_nx = LOAD;
          else if (IFG_CYCLES == 0) state_nx = IDLE;
          else                      state_nx = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Arbitration pointer, counters and word shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      grant_id  <= '0;
      grant_vec <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      shreg     <= '0;
      pkt_count <= '0;
`ifdef UDP_SCHED_SEQ_EN
      seq_idx   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb_hit) begin
            grant_id  <= arb_idx;
            grant_vec <= arb_grant;
            ptr       <= (arb_idx == GW'(N_SRC - 1)) ? '0 : arb_idx + GW'(1);
          end
        end
        HDR: begin
          if (bus.m_ready) begin
            word_cnt <= '0;
`ifdef UDP_SCHED_SEQ_EN
            seq_idx  <= 1'b0;
`endif
          end
        end
`ifdef UDP_SCHED_SEQ_EN
        SEQ: begin
          if (bus.m_ready) seq_idx <= 1'b1;
        end
`endif
        LOAD: begin
          if (word_avail) begin
            shreg    <= bus.src_data[grant_id];
            byte_cnt <= '0;
          end
        end
        SHIFT: begin
          if (bus.m_ready) begin
            shreg    <= shreg >> BW_out;
            byte_cnt <= byte_cnt + BCW'(1);
            if (last_byte) begin
              word_cnt <= word_cnt + WCW'(1);
              if (last_word) begin
                gap_cnt <= '0;
                if (IFG_CYCLES == 0) pkt_count <= pkt_count + 16'd1;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) pkt_count <= pkt_count + 16'd1;
          else                     gap_cnt   <= gap_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
